instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter W, default 9, instruction word width in bits.
REQ-002 Parameter D, default 12, address width; storage depth is 2**D words.
REQ-003 Parameter NOP, default all-zero W-bit word, returned for any non-servable fetch.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 load_start  input  1  one-cycle pulse; begins a program load at address 0.
REQ-007 load_valid  input  1  load_data holds a valid instruction word.
REQ-008 load_data  input  W  instruction word to store.
REQ-009 load_last  input  1  qualifies the current beat as the final program word.
REQ-010 load_ready  output  1  block accepts a load beat this cycle.
REQ-011 fetch_req  input  1  fetch request for prog_ctr.
REQ-012 prog_ctr  input  D  fetch address.
REQ-013 mach_code  output  W  fetched instruction, registered.
REQ-014 fetch_valid  output  1  mach_code/oob carry a response this cycle.
REQ-015 oob  output  1  the response is NOP because the address was not servable.
REQ-016 prog_len  output  D+1  number of words in the loaded program.
REQ-017 loaded  output  1  a complete program is resident (state READY).

Function
REQ-018 FSM states EMPTY, LOAD, READY; reset state EMPTY.
REQ-019 load_start in any state -> LOAD next cycle, write pointer 0, prog_len 0, loaded 0.
REQ-020 load_ready is 1 only in LOAD; a beat transfers when load_valid && load_ready.
REQ-021 Each transfer writes load_data to core[wptr], then wptr increments by 1.
REQ-022 Transfer with load_last -> READY; prog_len = wptr+1 (count including that word).
REQ-023 Transfer at wptr = 2**D-1 without load_last -> READY; prog_len = 2**D; no wrap.
REQ-024 load_start coinciding with a beat: the beat is dropped; the load restarts at 0.
REQ-025 load_valid outside LOAD is ignored; storage is unchanged.
REQ-026 fetch_req in cycle n -> fetch_valid=1 in cycle n+1 (1-cycle latency, no back-pressure).
REQ-027 No fetch_req in cycle n -> fetch_valid=0 in n+1; mach_code and oob hold their last values.
REQ-028 In READY, prog_ctr < prog_len -> mach_code = core[prog_ctr], oob=0.
REQ-029 In READY, prog_ctr >= prog_len -> mach_code = NOP, oob=1.
REQ-030 In EMPTY or LOAD, every fetch -> mach_code = NOP, oob=1.
REQ-031 State, prog_len and the fetch-permission check are sampled in the request cycle.

Reset
REQ-032 rst_n low -> immediately: state EMPTY, wptr 0, prog_len 0, loaded 0, load_ready 0, fetch_valid 0, oob 0, mach_code NOP.
REQ-033 Storage contents are not reset; after reset they are unreachable until a new load completes.
REQ-034 Reset asserted mid-load abandons the load; the partial program is not fetchable.

Structure
REQ-035 Shared package cpu_pkg holds the default W, the default D, the NOP encoding and the FSM state enum.
REQ-036 Storage is sub-module instr_mem_array: one synchronous write port and one synchronous read port, no reset.
REQ-037 The FSM, write pointer, prog_len and the fetch response register reside in instr_mem.

Verification
REQ-038 Reset, then fetch_req at prog_ctr=0 -> next cycle fetch_valid=1, mach_code=9'b000000000, oob=1.
REQ-039 load_start; load 9'b001111110, 9'b001100110, 9'b001111010 (last on the 3rd) -> prog_len=3, loaded=1; fetches at 0,1,2 return those words with oob=0; fetch at 3 -> NOP, oob=1.
REQ-040 load_valid held with gaps (valid pattern 1,0,1) -> only 2 words written, wptr advances twice.
REQ-041 D=2: load 5 words with no load_last -> READY after the 4th, prog_len=4, 5th beat ignored (load_ready=0).
REQ-042 rst_n pulsed low after 2 of 3 beats -> EMPTY, prog_len=0; fetch at 0 -> NOP, oob=1.
REQ-043 load_start while READY with prog_len=3 -> fetch at 0 in the next cycle returns NOP, oob=1; reload of 1 word -> prog_len=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default instruction/address widths, the NOP word
// and the instruction-memory load FSM states.
package cpu_pkg;

  localparam int INSTR_W = 9;
  localparam int ADDR_W  = 12;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_if.sv
// Load and fetch bus of the instruction memory; the master drives requests,
// the memory (slave) answers.
interface instr_mem_if #(
  parameter int W = cpu_pkg::INSTR_W,
  parameter int D = cpu_pkg::ADDR_W
) ();

  // Load beat transfers on a cycle where load_valid && load_ready are both high.
  logic         load_start;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_last;
  logic         load_ready;

  logic         fetch_req;
  logic [D-1:0] prog_ctr;
  logic [W-1:0] mach_code;
  logic         fetch_valid;
  logic         oob;
  logic [D:0]   prog_len;
  logic         loaded;

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, prog_ctr,
    output load_ready, mach_code, fetch_valid, oob, prog_len, loaded
  );

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, prog_ctr,
    input  load_ready, mach_code, fetch_valid, oob, prog_len, loaded
  );

endinterface

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Contents are never reset.
module instr_mem_array #(
  parameter int W = cpu_pkg::INSTR_W,
  parameter int D = cpu_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [D-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         re_i,
  input  logic [D-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] core_q [2**D];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) core_q[waddr_i] <= wdata_i;
  end

  // Read data only changes on a fetch, so it holds between requests.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= core_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem.sv
// Program-loadable instruction memory: load FSM, write pointer, program length
// and a one-cycle fetch response that returns NOP for non-servable addresses.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int           W   = INSTR_W,
  parameter int           D   = ADDR_W,
  parameter logic [W-1:0] NOP = W'(NOP_INSTR)
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_mem_if.slave   bus,
  output state_e       state_o
);

  localparam logic [D-1:0] LAST_ADDR = {D{1'b1}};
  localparam logic [D:0]   DEPTH     = {1'b1, {D{1'b0}}};

  state_e       state_q, state_d;
  logic [D-1:0] wptr_q, wptr_d;
  logic [D:0]   len_q, len_d;
  logic         fv_q, oob_q, hit_q;
  logic         wr_en, serve;
  logic [W-1:0] rdata;

  // A beat arriving together with load_start is dropped: the restart wins.
  assign wr_en = (state_q == LOAD) && bus.load_valid && !bus.load_start;
  assign serve = (state_q == READY) && ({1'b0, bus.prog_ctr} < len_q);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    if (bus.load_start) begin
      state_d = LOAD;
      wptr_d  = '0;
      len_d   = '0;
    end else if (wr_en) begin
      wptr_d = wptr_q + D'(1);
      if (bus.load_last) begin
        state_d = READY;
        len_d   = {1'b0, wptr_q} + (D+1)'(1);
      end else if (wptr_q == LAST_ADDR) begin
        state_d = READY;
        len_d   = DEPTH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wptr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
    end
  end

  // Servability is decided in the request cycle; hit/oob hold between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q  <= 1'b0;
      oob_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      fv_q <= bus.fetch_req;
      if (bus.fetch_req) begin
        hit_q <= serve;
        oob_q <= !serve;
      end
    end
  end

  instr_mem_array #(.W(W), .D(D)) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (bus.load_data),
    .re_i    (bus.fetch_req),
    .raddr_i (bus.prog_ctr),
    .rdata_o (rdata)
  );

  assign bus.mach_code   = hit_q ? rdata : NOP;
  assign bus.fetch_valid = fv_q;
  assign bus.oob         = oob_q;
  assign bus.prog_len    = len_q;
  assign bus.loaded      = (state_q == READY);
  assign bus.load_ready  = (state_q == LOAD);
  assign state_o         = state_q;

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: directed scenarios plus randomized traffic against a
// word-level reference model of the program memory.
module tb_instr_mem;
  import cpu_pkg::*;

  localparam int W = 9;
  localparam int D = 12;
  localparam int DEPTH = 2**D;
  localparam logic [W-1:0] NOP_W = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  state_e st1, st2;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_mem_if #(.W(W), .D(D)) bus ();
  instr_mem_if #(.W(W), .D(2)) bus2 ();

  instr_mem #(.W(W), .D(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .state_o(st1));

  instr_mem #(.W(W), .D(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .state_o(st2));

  // Reference model: 0 = no program, 1 = loading, 2 = program resident.
  int m_mode, m_wptr, m_len;
  logic [W-1:0] m_mem [DEPTH];
  logic m_fv, m_oob;
  logic [W-1:0] m_code;

  task automatic model_reset();
    m_mode = 0; m_wptr = 0; m_len = 0;
    m_fv = 0; m_oob = 0; m_code = NOP_W;
  endtask

  task automatic model_edge();
    if (bus.fetch_req) begin
      m_fv = 1;
      if (m_mode == 2 && int'(bus.prog_ctr) < m_len) begin
        m_code = m_mem[bus.prog_ctr];
        m_oob = 0;
      end else begin
        m_code = NOP_W;
        m_oob = 1;
      end
    end else begin
      m_fv = 0;
    end
    if (bus.load_start) begin
      m_mode = 1; m_wptr = 0; m_len = 0;
    end else if (m_mode == 1 && bus.load_valid) begin
      m_mem[m_wptr] = bus.load_data;
      if (bus.load_last) begin
        m_mode = 2; m_len = m_wptr + 1;
      end else if (m_wptr == DEPTH - 1) begin
        m_mode = 2; m_len = DEPTH;
      end else begin
        m_wptr++;
      end
    end
  endtask

  task automatic set_in(input logic start, input logic valid, input logic [W-1:0] data,
                        input logic last, input logic freq, input logic [D-1:0] pc);
    bus.load_start = start; bus.load_valid = valid; bus.load_data = data;
    bus.load_last = last; bus.fetch_req = freq; bus.prog_ctr = pc;
  endtask

  task automatic idle();
    set_in(0, 0, '0, 0, 0, '0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus2.load_start = 0; bus2.load_valid = 0; bus2.load_data = '0;
    bus2.load_last = 0; bus2.fetch_req = 0; bus2.prog_ctr = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b need 0", bus.fetch_valid); end
    tests++; if (bus.oob !== 1'b0) begin fails++; $display("FAIL reset_oob: got %b need 0", bus.oob); end
    tests++; if (bus.mach_code !== NOP_W) begin fails++; $display("FAIL reset_code: got %h need %h", bus.mach_code, NOP_W); end
    tests++; if (bus.prog_len !== '0) begin fails++; $display("FAIL reset_len: got %0d need 0", bus.prog_len); end
    tests++; if (bus.loaded !== 1'b0 || bus.load_ready !== 1'b0) begin fails++; $display("FAIL reset_flags: got loaded=%b ready=%b need 0 0", bus.loaded, bus.load_ready); end
    tests++; if (st1 !== EMPTY) begin fails++; $display("FAIL reset_state: got %0d need %0d", st1, EMPTY); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_empty();
    set_in(0, 0, '0, 0, 1, '0);
    tick();
    idle();
    tests++; if (bus.fetch_valid !== 1'b1 || bus.mach_code !== NOP_W || bus.oob !== 1'b1) begin
      fails++; $display("FAIL empty_fetch: got fv=%b code=%h oob=%b need 1 %h 1", bus.fetch_valid, bus.mach_code, bus.oob, NOP_W); end
    tick();
    tests++; if (bus.fetch_valid !== 1'b0 || bus.mach_code !== NOP_W || bus.oob !== 1'b1) begin
      fails++; $display("FAIL empty_hold: got fv=%b code=%h oob=%b need 0 %h 1", bus.fetch_valid, bus.mach_code, bus.oob, NOP_W); end
  endtask

  task automatic test_load_directed();
    logic [W-1:0] words [3];
    logic [W-1:0] exp_code;
    words[0] = 9'b001111110; words[1] = 9'b001100110; words[2] = 9'b001111010;
    set_in(1, 0, '0, 0, 0, '0);
    tick();
    tests++; if (bus.load_ready !== 1'b1 || st1 !== LOAD) begin fails++; $display("FAIL load_enter: got ready=%b state=%0d need 1 %0d", bus.load_ready, st1, LOAD); end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, words[i], i == 2, 0, '0);
      tick();
    end
    idle();
    tests++; if (bus.prog_len !== 13'd3 || bus.loaded !== 1'b1 || bus.load_ready !== 1'b0) begin
      fails++; $display("FAIL load_done: got len=%0d loaded=%b ready=%b need 3 1 0", bus.prog_len, bus.loaded, bus.load_ready); end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, '0, 0, 1, D'(i));
      tick();
      idle();
      exp_code = (i < 3) ? words[i] : NOP_W;
      tests++; if (bus.fetch_valid !== 1'b1 || bus.mach_code !== exp_code || bus.oob !== (i >= 3)) begin
        fails++; $display("FAIL load_fetch%0d: got fv=%b code=%h oob=%b need 1 %h %b", i, bus.fetch_valid, bus.mach_code, bus.oob, exp_code, i >= 3); end
    end
  endtask

  task automatic test_valid_gaps();
    logic [W-1:0] a, b;
    a = W'($urandom); b = W'($urandom);
    set_in(1, 0, '0, 0, 0, '0); tick();
    set_in(0, 1, a, 0, 0, '0); tick();
    set_in(0, 0, W'($urandom), 1, 0, '0); tick();
    tests++; if (st1 !== LOAD || bus.load_ready !== 1'b1) begin fails++; $display("FAIL gap_hold: got state=%0d ready=%b need %0d 1", st1, bus.load_ready, LOAD); end
    set_in(0, 1, b, 1, 0, '0); tick();
    idle();
    tests++; if (bus.prog_len !== 13'd2) begin fails++; $display("FAIL gap_len: got %0d need 2", bus.prog_len); end
    set_in(0, 0, '0, 0, 1, 12'd0); tick();
    tests++; if (bus.mach_code !== a || bus.oob !== 1'b0) begin fails++; $display("FAIL gap_w0: got %h oob=%b need %h 0", bus.mach_code, bus.oob, a); end
    set_in(0, 0, '0, 0, 1, 12'd1); tick();
    tests++; if (bus.mach_code !== b || bus.oob !== 1'b0) begin fails++; $display("FAIL gap_w1: got %h oob=%b need %h 0", bus.mach_code, bus.oob, b); end
    set_in(0, 0, '0, 0, 1, 12'd2); tick();
    idle();
    tests++; if (bus.mach_code !== NOP_W || bus.oob !== 1'b1) begin fails++; $display("FAIL gap_w2: got %h oob=%b need %h 1", bus.mach_code, bus.oob, NOP_W); end
  endtask

  task automatic test_start_with_beat();
    logic [W-1:0] c;
    c = W'($urandom);
    set_in(1, 0, '0, 0, 0, '0); tick();
    set_in(0, 1, W'($urandom), 0, 0, '0); tick();
    set_in(1, 1, ~c, 1, 0, '0); tick();
    tests++; if (bus.loaded !== 1'b0 || bus.prog_len !== '0 || st1 !== LOAD) begin
      fails++; $display("FAIL drop_beat: got loaded=%b len=%0d state=%0d need 0 0 %0d", bus.loaded, bus.prog_len, st1, LOAD); end
    set_in(0, 1, c, 1, 0, '0); tick();
    set_in(0, 0, '0, 0, 1, 12'd0); tick();
    idle();
    tests++; if (bus.prog_len !== 13'd1 || bus.mach_code !== c || bus.oob !== 1'b0) begin
      fails++; $display("FAIL restart_word: got len=%0d code=%h oob=%b need 1 %h 0", bus.prog_len, bus.mach_code, bus.oob, c); end
  endtask

  task automatic test_restart();
    logic [W-1:0] w;
    w = W'($urandom);
    set_in(1, 0, '0, 0, 0, '0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, W'($urandom), i == 2, 0, '0); tick();
    end
    tests++; if (bus.prog_len !== 13'd3 || bus.loaded !== 1'b1) begin fails++; $display("FAIL rl_pre: got len=%0d loaded=%b need 3 1", bus.prog_len, bus.loaded); end
    set_in(1, 0, '0, 0, 0, '0); tick();
    set_in(0, 0, '0, 0, 1, 12'd0); tick();
    tests++; if (bus.fetch_valid !== 1'b1 || bus.mach_code !== NOP_W || bus.oob !== 1'b1) begin
      fails++; $display("FAIL rl_fetch: got fv=%b code=%h oob=%b need 1 %h 1", bus.fetch_valid, bus.mach_code, bus.oob, NOP_W); end
    set_in(0, 1, w, 1, 0, '0); tick();
    idle();
    tests++; if (bus.prog_len !== 13'd1 || bus.loaded !== 1'b1) begin fails++; $display("FAIL rl_len: got len=%0d loaded=%b need 1 1", bus.prog_len, bus.loaded); end
  endtask

  task automatic test_reset_mid_load();
    set_in(1, 0, '0, 0, 0, '0); tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, W'($urandom), 0, 0, '0); tick();
    end
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++; if (st1 !== EMPTY || bus.prog_len !== '0 || bus.loaded !== 1'b0 || bus.load_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_state: got state=%0d len=%0d loaded=%b ready=%b need %0d 0 0 0", st1, bus.prog_len, bus.loaded, bus.load_ready, EMPTY); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_in(0, 0, '0, 0, 1, 12'd0); tick();
    idle();
    tests++; if (bus.fetch_valid !== 1'b1 || bus.mach_code !== NOP_W || bus.oob !== 1'b1) begin
      fails++; $display("FAIL midrst_fetch: got fv=%b code=%h oob=%b need 1 %h 1", bus.fetch_valid, bus.mach_code, bus.oob, NOP_W); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      set_in($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, W'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, D'($urandom_range(0, 24)));
      tick();
      tests++; if (bus.fetch_valid !== m_fv) begin fails++; $display("FAIL rnd_fv c%0d: got %b need %b", c, bus.fetch_valid, m_fv); end
      tests++; if (bus.mach_code !== m_code || bus.oob !== m_oob) begin
        fails++; $display("FAIL rnd_resp c%0d: got %h oob=%b need %h %b", c, bus.mach_code, bus.oob, m_code, m_oob); end
      tests++; if (int'(bus.prog_len) != m_len || bus.loaded !== (m_mode == 2) || bus.load_ready !== (m_mode == 1)) begin
        fails++; $display("FAIL rnd_ctl c%0d: got len=%0d loaded=%b ready=%b need %0d %b %b", c, bus.prog_len, bus.loaded, bus.load_ready, m_len, m_mode == 2, m_mode == 1); end
    end
    idle();
    tick();
  endtask

  task automatic test_full_depth();
    logic [W-1:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = W'($urandom);
    bus2.load_start = 1; tick(); bus2.load_start = 0;
    for (int i = 0; i < 5; i++) begin
      bus2.load_valid = 1; bus2.load_data = w[i]; bus2.load_last = 0;
      tests++; if (bus2.load_ready !== (i < 4)) begin fails++; $display("FAIL full_ready%0d: got %b need %b", i, bus2.load_ready, i < 4); end
      tick();
    end
    bus2.load_valid = 0;
    tests++; if (bus2.prog_len !== 3'd4 || bus2.loaded !== 1'b1 || st2 !== READY) begin
      fails++; $display("FAIL full_len: got len=%0d loaded=%b state=%0d need 4 1 %0d", bus2.prog_len, bus2.loaded, st2, READY); end
    for (int i = 0; i < 4; i++) begin
      bus2.fetch_req = 1; bus2.prog_ctr = 2'(i);
      tick();
      bus2.fetch_req = 0;
      tests++; if (bus2.mach_code !== w[i] || bus2.oob !== 1'b0 || bus2.fetch_valid !== 1'b1) begin
        fails++; $display("FAIL full_fetch%0d: got %h oob=%b fv=%b need %h 0 1", i, bus2.mach_code, bus2.oob, bus2.fetch_valid, w[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_empty();
    test_load_directed();
    test_valid_gaps();
    test_start_with_beat();
    test_restart();
    test_reset_mid_load();
    test_random();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
